icache_direct: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 8 +
 rtl/icache_types_pkg.sv | 28 ++
 rtl/icache_array.sv | 46 ++++
 rtl/icache_direct.sv | 124 ++++++++++++
 tb/tb_icache_direct.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/icache_types_pkg.sv
// Instruction-cache types: address split, frame layout and controller states.
// The struct layouts describe the default 16-set, word-aligned geometry.
package icache_types_pkg;
    import cpu_types_pkg::*;

    localparam int IC_SETS     = 16;
    localparam int IC_PC_ALIGN = 2;
    localparam int IC_IDX_W    = $clog2(IC_SETS);
    localparam int IC_TAG_W    = WORD_W - IC_IDX_W - IC_PC_ALIGN;

    typedef struct packed {
        logic [IC_TAG_W-1:0]    tag;
        logic [IC_IDX_W-1:0]    idx;
        logic [IC_PC_ALIGN-1:0] bytoff;
    } icachef_t;

    typedef struct packed {
        logic                valid;
        logic [IC_TAG_W-1:0] tag;
        word_t               data;
    } icache_frame_t;

    typedef enum logic {
        IC_IDLE  = 1'b0,
        IC_FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame store: combinational read, single-port synchronous write,
// valid bits cleared asynchronously on reset (tags/data left uninitialised).
module icache_array
    import cpu_types_pkg::*;
    import icache_types_pkg::*;
#(
    parameter int SETS  = IC_SETS,
    parameter int TAG_W = IC_TAG_W
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [$clog2(SETS)-1:0]  rd_idx,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output word_t                    rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(SETS)-1:0]  wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  word_t                    wr_data
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags  [SETS];
    word_t            words [SETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload has no reset so it can map onto plain storage.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = words[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with a single outstanding fill.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_direct
    import cpu_types_pkg::*;
    import icache_types_pkg::*;
#(
    parameter int SETS     = 16,
    parameter int PC_ALIGN = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - PC_ALIGN;

    icache_state_t    state, next_state;
    word_t            miss_addr;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_data;
    logic             lookup_hit;
    logic             ihit_c, iren_c, fill, miss;
    logic             unused_offset;

    assign req_idx       = imemaddr[PC_ALIGN+IDX_W-1:PC_ALIGN];
    assign req_tag       = imemaddr[31:PC_ALIGN+IDX_W];
    assign unused_offset = ^imemaddr[PC_ALIGN-1:0];

    icache_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_array (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill),
        .wr_idx   (miss_addr[PC_ALIGN+IDX_W-1:PC_ALIGN]),
        .wr_tag   (miss_addr[31:PC_ALIGN+IDX_W]),
        .wr_data  (iload)
    );

    assign lookup_hit = imemREN & rd_valid & (rd_tag == req_tag);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IC_IDLE;
            miss_addr <= '0;
        end else begin
            state <= next_state;
            if (miss) begin
                miss_addr <= {imemaddr[31:PC_ALIGN], {PC_ALIGN{1'b0}}};
            end
        end
    end

    // The fill is never cancelled: a redirect or dropped request during FETCH
    // still installs the missed line, and the new address is looked up after.
    always_comb begin
        next_state = state;
        ihit_c     = 1'b0;
        iren_c     = 1'b0;
        fill       = 1'b0;
        miss       = 1'b0;
        unique case (state)
            IC_IDLE: begin
                ihit_c = lookup_hit;
                if (imemREN && !lookup_hit) begin
                    miss       = 1'b1;
                    next_state = IC_FETCH;
                end
            end
            IC_FETCH: begin
                iren_c = 1'b1;
                if (!iwait) begin
                    fill       = 1'b1;
                    next_state = IC_IDLE;
                end
            end
            default: next_state = IC_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign ihit     = ihit_c & nRST;
    assign iREN     = iren_c & nRST;
    assign iaddr    = nRST ? miss_addr : '0;
    assign imemload = nRST ? rd_data : '0;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit_c && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct; memory is driven by hand.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic [31:0] iload = '0;
    logic        iwait = 1'b1;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    icache_direct dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Miss on a, memory busy nwait cycles, then returns d.
    task automatic do_miss(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input int nwait, input bit keep_req);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        iload    = 32'hDEAD_BEEF;
        #1;
        chk({tag, ".lookup_ihit"}, {31'd0, ihit}, 32'd0);
        chk({tag, ".lookup_iren"}, {31'd0, iREN}, 32'd0);
        step;
        for (int i = 0; i < nwait; i++) begin
            chk({tag, ".wait_ihit"}, {31'd0, ihit}, 32'd0);
            chk({tag, ".wait_iren"}, {31'd0, iREN}, 32'd1);
            chk({tag, ".wait_iaddr"}, iaddr, a);
            step;
        end
        iwait = 1'b0;
        iload = d;
        #1;
        chk({tag, ".resp_iren"}, {31'd0, iREN}, 32'd1);
        chk({tag, ".resp_iaddr"}, iaddr, a);
        chk({tag, ".resp_ihit"}, {31'd0, ihit}, 32'd0);
        step;
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        if (keep_req) begin
            #1;
            chk({tag, ".refill_ihit"}, {31'd0, ihit}, 32'd1);
            chk({tag, ".refill_load"}, imemload, d);
            chk({tag, ".refill_iren"}, {31'd0, iREN}, 32'd0);
        end else begin
            imemREN = 1'b0;
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.ihit", {31'd0, ihit}, 32'd0);
        chk("rst.iren", {31'd0, iREN}, 32'd0);
        chk("rst.iaddr", iaddr, 32'd0);
        chk("rst.imemload", imemload, 32'd0);
        nRST = 1'b1;
        step;

        // cold miss: 1 lookup + 3 busy + 1 response cycle without ihit
        do_miss("cold", 32'h0000_0000, 32'h3C01_0001, 3, 1'b1);
        step;

        // idle without request
        imemREN = 1'b0;
        #1;
        chk("noreq.ihit", {31'd0, ihit}, 32'd0);
        step;
        chk("noreq.iren", {31'd0, iREN}, 32'd0);

        // hit after fill
        do_miss("f4", 32'h0000_0004, 32'h1111_0004, 1, 1'b1);
        step;
        do_miss("f8", 32'h0000_0008, 32'h1111_0008, 0, 1'b1);
        step;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0004;
        #1;
        chk("hit4.ihit", {31'd0, ihit}, 32'd1);
        chk("hit4.load", imemload, 32'h1111_0004);
        chk("hit4.iren", {31'd0, iREN}, 32'd0);
        imemaddr = 32'h0000_0000;
        #1;
        chk("hit0.load", imemload, 32'h3C01_0001);
        step;
        chk("hit.stay_idle", {31'd0, iREN}, 32'd0);

        // conflict on index 4
        do_miss("c10", 32'h0000_0010, 32'h2222_0010, 2, 1'b1);
        step;
        do_miss("c50", 32'h0000_0050, 32'h2222_0050, 1, 1'b1);
        step;
        do_miss("c10b", 32'h0000_0010, 32'h2222_0010, 0, 1'b1);
        step;

        // redirect mid-fill
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0020;
        iwait    = 1'b1;
        #1;
        chk("redir.miss20", {31'd0, ihit}, 32'd0);
        step;
        imemaddr = 32'h0000_0100;
        #1;
        chk("redir.iren", {31'd0, iREN}, 32'd1);
        chk("redir.iaddr", iaddr, 32'h0000_0020);
        chk("redir.ihit", {31'd0, ihit}, 32'd0);
        step;
        iwait = 1'b0;
        iload = 32'h3333_0020;
        #1;
        chk("redir.resp_iaddr", iaddr, 32'h0000_0020);
        step;
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        #1;
        chk("redir.miss100", {31'd0, ihit}, 32'd0);
        chk("redir.idle_iren", {31'd0, iREN}, 32'd0);
        step;
        chk("redir.iaddr100", iaddr, 32'h0000_0100);
        iwait = 1'b0;
        iload = 32'h3333_0100;
        step;
        iwait = 1'b1;
        #1;
        chk("redir.hit100", {31'd0, ihit}, 32'd1);
        chk("redir.load100", imemload, 32'h3333_0100);
        imemaddr = 32'h0000_0020;
        #1;
        chk("redir.hit20", {31'd0, ihit}, 32'd1);
        chk("redir.load20", imemload, 32'h3333_0020);
        step;

        // reset mid-fill; late response must be ignored
        imemaddr = 32'h0000_000C;
        #1;
        chk("rstf.miss", {31'd0, ihit}, 32'd0);
        step;
        chk("rstf.iren_pre", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rstf.iren", {31'd0, iREN}, 32'd0);
        chk("rstf.ihit", {31'd0, ihit}, 32'd0);
        chk("rstf.iaddr", iaddr, 32'd0);
        chk("rstf.imemload", imemload, 32'd0);
        iwait = 1'b0;
        iload = 32'hDEAD_BEEF;
        step;
        step;
        imemREN = 1'b0;
        nRST    = 1'b1;
        step;
        chk("rstf.late_iren", {31'd0, iREN}, 32'd0);
        iwait   = 1'b1;
        imemREN = 1'b1;
        imemaddr = 32'h0000_0000; #1; chk("rstf.cold0",   {31'd0, ihit}, 32'd0);
        imemaddr = 32'h0000_0004; #1; chk("rstf.cold4",   {31'd0, ihit}, 32'd0);
        imemaddr = 32'h0000_0050; #1; chk("rstf.cold50",  {31'd0, ihit}, 32'd0);
        imemaddr = 32'h0000_0100; #1; chk("rstf.cold100", {31'd0, ihit}, 32'd0);
        imemaddr = 32'h0000_0020; #1; chk("rstf.cold20",  {31'd0, ihit}, 32'd0);
        imemREN = 1'b0;
        step;
        chk("rstf.idle_iren", {31'd0, iREN}, 32'd0);

`ifdef ICACHE_STATS_EN
        nRST = 1'b0;
        #1;
        chk("stats.rst_hit", hit_count, 32'd0);
        chk("stats.rst_miss", miss_count, 32'd0);
        nRST = 1'b1;
        step;
        for (int i = 0; i < 4; i++) begin
            do_miss("stats.fill", 32'h0000_0200 + 32'(i * 4), 32'h0000_A000 + 32'(i), 1, 1'b0);
        end
        step;
        for (int i = 0; i < 4; i++) begin
            imemREN  = 1'b1;
            imemaddr = 32'h0000_0200 + 32'(i * 4);
            #1;
            chk("stats.hit", {31'd0, ihit}, 32'd1);
            step;
        end
        imemREN = 1'b0;
        #1;
        chk("stats.hit_count", hit_count, 32'd4);
        chk("stats.miss_count", miss_count, 32'd4);
        force dut.hit_count = 32'hFFFF_FFFF;
        #1;
        release dut.hit_count;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0200;
        #1;
        chk("stats.sat_ihit", {31'd0, ihit}, 32'd1);
        step;
        imemREN = 1'b0;
        #1;
        chk("stats.sat", hit_count, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
